// File: rtl/ahbl_waitstate_sram.sv
// ahbl_waitstate_sram
//
// AHB-Lite slave wrapping a word-organised SRAM. Every accepted transfer gets
// a configurable or LFSR-derived number of wait states, and illegal accesses
// get a two-cycle ERROR response. It is intended as a crossbar test target.
// Illegal means out of range, an oversized hsize, or a misaligned address.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ahbls_hready       bus-level HREADY (address phase qualifier)
//   ahbls_hready_resp  this slave's HREADYOUT
//   ahbls_hresp        1 = ERROR
//   ahbls_haddr/hwrite/htrans/hsize  address-phase controls
//   ahbls_hburst/hprot/hmastlock     accepted but ignored
//   ahbls_hwdata       write data (sampled in the completing cycle)
//   ahbls_hrdata       read data (zero outside a read data phase)
//
// All outputs are decoded from registered state only.

module ahbl_waitstate_sram #(
    parameter int unsigned W_ADDR      = 32,
    parameter int unsigned W_DATA      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MAX_WAIT    = 3,
    parameter bit          RANDOM_WAIT = 1'b1,
    parameter logic [7:0]  LFSR_SEED   = 8'h5a
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int unsigned       W_IDX      = $clog2(DEPTH);
    localparam logic [W_ADDR-1:0] ADDR_LIMIT = W_ADDR'(DEPTH * 4);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StLast = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [W_IDX-1:0] idx_q, idx_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             write_q, write_d;

    logic             accept;
    logic             illegal;
    logic [2:0]       wait_sel;
    logic [3:0]       byte_en;
    logic             mem_we;

    logic [W_DATA-1:0] mem [DEPTH];

    logic unused_ok;
    assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0]};

    // ---------------------------------------------------------------------
    // Address-phase decode
    // ---------------------------------------------------------------------
    assign accept = ahbls_hready && ahbls_htrans[1];

    assign illegal = (ahbls_haddr >= ADDR_LIMIT)
                  || (ahbls_hsize > 3'd2)
                  || ((ahbls_hsize == 3'd1) && ahbls_haddr[0])
                  || ((ahbls_hsize == 3'd2) && (ahbls_haddr[1:0] != 2'b00));

    always_comb begin
        if (RANDOM_WAIT) begin
            wait_sel = 3'(32'(lfsr_q[2:0]) % (MAX_WAIT + 1));
        end else begin
            wait_sel = 3'(MAX_WAIT);
        end
    end

    // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1. Free-running.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // ---------------------------------------------------------------------
    // Data-phase state machine
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        size_d     = size_q;
        write_d    = write_q;

        unique case (state_q)
            StIdle, StLast, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    idx_d   = ahbls_haddr[W_IDX+1:2];
                    lane_d  = ahbls_haddr[1:0];
                    size_d  = ahbls_hsize[1:0];
                    write_d = ahbls_hwrite;
                    if (illegal) begin
                        state_d = StErr1;
                    end else if (wait_sel == 3'd0) begin
                        state_d = StLast;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = wait_sel;
                    end
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    state_d = StLast;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 3'd0;
            lfsr_q     <= LFSR_SEED;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            write_q    <= write_d;
        end
    end

    // ---------------------------------------------------------------------
    // Memory: writes commit at the end of the completing (LAST) cycle, so a
    // read issued back-to-back sees the new data in its own data phase.
    // Errored writes never reach LAST and therefore never commit.
    // ---------------------------------------------------------------------
    always_comb begin
        unique case (size_q)
            2'd0:    byte_en = 4'b0001 << lane_q;
            2'd1:    byte_en = 4'b0011 << lane_q;
            default: byte_en = 4'b1111;
        endcase
    end

    assign mem_we = (state_q == StLast) && write_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx_q][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ahbls_hready_resp = !((state_q == StWait) || (state_q == StErr1));
    assign ahbls_hresp       = (state_q == StErr1) || (state_q == StErr2);
    assign ahbls_hrdata      = (((state_q == StWait) || (state_q == StLast)) && !write_q)
                             ? mem[idx_q] : '0;

endmodule

// File: doc/ahbl_waitstate_sram.md
# ahbl_waitstate_sram

Synthesisable AHB-Lite slave: a word-organised SRAM model with pseudo-random wait-state insertion and ERROR responses for illegal accesses. It sits directly downstream of the AHB-Lite crossbar. It is the target that crossbar bench masters write to and read back from. The randomised HREADY stalls and two-cycle error responses exercise the crossbar's data-phase routing and backpressure paths.

## Interface
- W_ADDR, 32, address width
- W_DATA, 32, data width; only 32 is supported
- DEPTH, 256, memory size in 32-bit words; must be a power of 2
- MAX_WAIT, 3, maximum wait states per transfer; range 0..7
- RANDOM_WAIT, 1, selects the wait-state source
  - 1: wait count is LFSR-derived
  - 0: every OKAY transfer takes exactly MAX_WAIT waits
- LFSR_SEED, 8'h5a, LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ahbls_hready  in  1  bus-level HREADY from the crossbar
- ahbls_hready_resp  out  1  this slave's HREADYOUT
- ahbls_hresp  out  1  1 = ERROR
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  size
- ahbls_hburst  in  3  ignored
- ahbls_hprot  in  4  ignored
- ahbls_hmastlock  in  1  ignored
- ahbls_hwdata  in  W_DATA  write data
- ahbls_hrdata  out  W_DATA  read data

## Operation
**Address-phase accept**
- A transfer is accepted when ahbls_hready && ahbls_htrans[1] (NSEQ or SEQ) on a rising edge.
- On accept, capture: haddr, hwrite, hsize, error flag, wait count.
- IDLE or BUSY accepted with hready high gives a zero-wait OKAY; no state is captured.
- Nothing is accepted while ahbls_hready is low.

**Illegal access (error flag set)** — any of:
- haddr ≥ DEPTH*4
- hsize > 2
- misaligned address: halfword with haddr[0]=1, or word with haddr[1:0]≠0

**Wait count**
- RANDOM_WAIT=1: lfsr[2:0] mod (MAX_WAIT+1), sampled at accept.
- RANDOM_WAIT=0: MAX_WAIT.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle regardless of bus activity.

**Data-phase state machine**
- IDLE
  - Outputs: hready_resp=1, hresp=0.
  - Accept with error flag → ERR1.
  - Accept with wait count 0 → LAST.
  - Accept with wait count > 0 → WAIT.
- WAIT
  - Outputs: hready_resp=0, hresp=0.
  - Down-counter decrements each cycle; moves to LAST on the cycle after it reaches 1.
- LAST
  - Outputs: hready_resp=1, hresp=0. The transfer completes this cycle.
  - A new accept in this same cycle follows the IDLE rules (back-to-back transfers, no bubble).
  - Otherwise → IDLE.
- ERR1
  - Outputs: hready_resp=0, hresp=1.
  - → ERR2 unconditionally.
- ERR2
  - Outputs: hready_resp=1, hresp=1.
  - New accepts follow the IDLE rules.
  - Error transfers never take wait states.
  - An erroring write leaves memory unmodified.

**Writes**
- hwdata is sampled on the LAST cycle and committed at the end of that cycle.
- Byte enables are derived from the captured hsize and addr[1:0]:
  - byte: 1<<addr[1:0]
  - halfword: 4'b0011 << addr[1:0]
  - word: 4'hf
- Word index = addr[log2(DEPTH*4)-1:2].

**Reads**
- hrdata = mem[captured word index] (full word, all lanes) while in WAIT or LAST for a read.
- hrdata = 0 in every other state.
- A read immediately following a write to the same address returns the new data, because the write commits before the read's data phase begins.

## Timing
- Reset values: hready_resp=1, hresp=0, hrdata=0, state IDLE, wait counter 0, lfsr=LFSR_SEED. Memory contents are not reset and are undefined after power-up.
- Reset asserted mid-transfer: the slave returns asynchronously to IDLE outputs; a pending write is discarded.
- Latency:
  - OKAY transfer: data phase is 1+N cycles for N wait states.
  - ERROR transfer: always 2 cycles.
- hrdata and hready_resp/hresp are combinational from registered state only; there is no combinational path from address-phase inputs to any output.
- MAX_WAIT=0 with RANDOM_WAIT=1 gives zero-wait on every legal transfer.

## Test plan
- Word write 32'hdeadbeef at 0x10, then word read at 0x10, RANDOM_WAIT=0, MAX_WAIT=2 → each data phase holds hready_resp=0 for exactly 2 cycles; read returns 32'hdeadbeef.
- Byte writes 8'h11, 8'h22, 8'h33, 8'h44 to 0x20..0x23 on the correct lanes, then word read at 0x20 → 32'h44332211; halfword write 16'hbeef to 0x22, read 0x20 → 32'hbeef2211.
- Word read at DEPTH*4 (0x400), and separately word write at 0x02 → ERR1 (hready_resp=0, hresp=1) then ERR2 (hready_resp=1, hresp=1); the word at 0x00 is unchanged.
- Back-to-back NSEQ writes every cycle for 64 addresses with RANDOM_WAIT=1, then read back → all data matches; no accepts occur while ahbls_hready is low; wait counts observed span 0..3.
- IDLE and BUSY with hready high for 10 cycles → hready_resp=1, hresp=0, hrdata=0 throughout; the LFSR still advances.
- rst_n pulsed low during the WAIT phase of a write of 32'h12345678 to 0x40 (prior value 0) → outputs take reset values immediately; a later read of 0x40 returns 0.
